// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// The unit issues one word request at a time to instruction memory and
// buffers the returned words, each with its address, in a small FIFO. It
// presents the FIFO head to decode with a valid/ready handshake. A redirect
// from a later stage flushes the buffer and restarts fetch at a new address.
// A request that is still in flight when a redirect arrives has its response
// dropped.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        instruction buffer entries (1..4)
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   imem_req     one-cycle request strobe to instruction memory
//   imem_addr    word address of the request
//   imem_rdata   returned instruction word
//   imem_valid   response strobe
//   redirect     redirect request from a later stage
//   redirect_pc  new fetch address, sampled with redirect
//   instr        instruction at the buffer head
//   instr_pc     address of instr
//   instr_valid  buffer non-empty
//   instr_ready  decode accepts instr this cycle
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]       DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [15:0]      pc, pc_nxt;
  logic [31:0]      buf_instr [DEPTH];
  logic [15:0]      buf_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [2:0]       count;
  logic             issue, push, pop, has_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state / request logic. Only one request is ever outstanding, so the
  // occupancy test at issue time is enough to guarantee the push has room.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      FETCH: begin
        issue = (count < DEPTH_C) && !redirect;
        if (redirect) begin
          pc_nxt = redirect_pc;
        end else if (issue) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          // A response in the same cycle as the redirect is simply dropped;
          // otherwise the response is still in flight and must be drained.
          state_nxt = imem_valid ? FETCH : DRAIN;
        end else if (imem_valid) begin
          push      = 1'b1;
          pc_nxt    = pc + 16'd1;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt = redirect_pc;
        end
        if (imem_valid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign has_entry   = (count != 3'd0);
  assign instr_valid = has_entry && !reset;
  assign pop         = instr_valid && instr_ready;
  assign imem_req    = issue && !reset;
  assign imem_addr   = pc;
  assign instr       = instr_valid ? buf_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : 16'h0;

  // Control state: FSM, fetch PC and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= 3'd0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage: written on push, never reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= pc;
    end
  end

endmodule
